// File: rtl/scanner_pkg.sv
// Shared scanner definitions: FSM state codes and common widths.
package scanner_pkg;

  localparam int STATE_W = 3;
  localparam int PROG_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    LOW_POWER    = 3'd0,
    STANDBY      = 3'd1,
    SCANNING     = 3'd2,
    IDLE         = 3'd3,
    TRANSFERRING = 3'd4,
    FLUSHING     = 3'd5
  } scan_state_e;

endpackage

// File: rtl/scanner_buffer_if.sv
// Scanner buffer bus: FSM state, sample input, drain handshake, status.
interface scanner_buffer_if
  import scanner_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [STATE_W-1:0] state;
  logic [DATA_W-1:0]  scan_data;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic [PROG_W-1:0]  prog;
  logic               near_full;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               done;

  modport master (
    output state, scan_data, out_ready,
    input  out_data, out_valid, prog,
    input  near_full, full, empty,
    input  overflow, done
  );

  modport slave (
    input  state, scan_data, out_ready,
    output out_data, out_valid, prog,
    output near_full, full, empty,
    output overflow, done
  );

endinterface

// File: rtl/scan_fifo_mem.sv
// Circular sample store: sync write, async read, wrapping pointers.
module scan_fifo_mem #(
  parameter int DATA_W   = 8,
  parameter int CAPACITY = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(CAPACITY);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(CAPACITY - 1);

  logic [DATA_W-1:0] mem_q [CAPACITY];
  logic [DATA_W-1:0] mem_d [CAPACITY];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = nxt(wr_ptr_q);
      end
      if (rd_en) rd_ptr_d = nxt(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/scanner_buffer.sv
// Scanner data-path: paced capture into a circular buffer, drain or flush.
module scanner_buffer
  import scanner_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CAPACITY = 10,
  parameter int SCAN_DIV = 4,
  parameter int NEAR_LVL = 8
) (
  input  logic clk,
  input  logic reset,
  scanner_buffer_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [PROG_W-1:0] prog_q, prog_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic scanning, xfer, flushing, low_pwr;
  logic tick, wr_en, pop, empty, full;

  always_comb begin
    scanning = (bus.state == SCANNING);
    xfer     = (bus.state == TRANSFERRING);
    flushing = (bus.state == FLUSHING);
    low_pwr  = (bus.state == LOW_POWER);
    empty    = (prog_q == '0);
    full     = (prog_q == PROG_W'(CAPACITY));
    tick     = scanning && (div_q == DIV_W'(SCAN_DIV - 1));
    wr_en    = tick && !full;
    pop      = (xfer && !empty && bus.out_ready)
            || (flushing && !empty);

    div_d = '0;
    if (scanning && !tick) div_d = div_q + 1'b1;

    prog_d = prog_q;
    ovf_d  = ovf_q;
    if (low_pwr) begin
      prog_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (wr_en)    prog_d = prog_q + 1'b1;
      else if (pop) prog_d = prog_q - 1'b1;
      if (tick && full) ovf_d = 1'b1;
      if (flushing)     ovf_d = 1'b0;
    end

    // pulse only when a pop drains the final entry
    done_d = pop && (prog_q == PROG_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      prog_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      prog_q <= prog_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  scan_fifo_mem #(
    .DATA_W  (DATA_W),
    .CAPACITY(CAPACITY)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .clr    (low_pwr),
    .wr_en  (wr_en),
    .wr_data(bus.scan_data),
    .rd_en  (pop),
    .rd_data(bus.out_data)
  );

  assign bus.out_valid = xfer && !empty;
  assign bus.prog      = prog_q;
  assign bus.near_full = (prog_q >= PROG_W'(NEAR_LVL));
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = ovf_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_scanner_buffer.sv
// Directed bench for scanner_buffer with a queue model of the buffer.
module tb_scanner_buffer;
  import scanner_pkg::*;

  localparam int CAP = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  byte unsigned q[$];
  logic         ovf_exp = 1'b0;
  int           done_cnt;

  scanner_buffer_if #(.DATA_W(8)) bus ();

  scanner_buffer #(
    .DATA_W  (8),
    .CAPACITY(CAP),
    .SCAN_DIV(4),
    .NEAR_LVL(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".prog"}, 32'(bus.prog), 32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == CAP));
    chk({tag, ".near"}, 32'(bus.near_full), 32'(q.size() >= 8));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(ovf_exp));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".prog"}, 32'(bus.prog), 0);
    chk({tag, ".empty"}, 32'(bus.empty), 1);
    chk({tag, ".full"}, 32'(bus.full), 0);
    chk({tag, ".near"}, 32'(bus.near_full), 0);
    chk({tag, ".valid"}, 32'(bus.out_valid), 0);
    chk({tag, ".ovf"}, 32'(bus.overflow), 0);
    chk({tag, ".done"}, 32'(bus.done), 0);
  endtask

  // n cycles of SCANNING, sample = base + cycle; divider starts aligned
  task automatic scan_run(input int n, input int base);
    bus.state = SCANNING;
    for (int i = 0; i < n; i++) begin
      bus.scan_data = 8'(base + i);
      tick();
      if (i % 4 == 3) begin
        if (q.size() < CAP) q.push_back(8'(base + i));
        else ovf_exp = 1'b1;
      end
      chk_status("scan");
      chk("scan.done", 32'(bus.done), 0);
    end
  endtask

  task automatic xfer(input int n, input bit toggle);
    int acc;
    bit popped;
    acc = 0;
    bus.state = TRANSFERRING;
    for (int k = 0; k < 4 * n + 4 && acc < n; k++) begin
      bus.out_ready = toggle ? (k % 2 == 0) : 1'b1;
      #1;
      chk("xfer.valid", 32'(bus.out_valid), 32'(q.size() > 0));
      popped = (q.size() > 0) && bus.out_ready;
      if (popped) chk("xfer.data", 32'(bus.out_data), 32'(q[0]));
      tick();
      if (popped) begin
        void'(q.pop_front());
        acc++;
      end
      chk_status("xfer");
      chk("xfer.done", 32'(bus.done), 32'(popped && q.size() == 0));
      if (bus.done) done_cnt++;
    end
    chk("xfer.count", acc, n);
    bus.out_ready = 1'b0;
  endtask

  task automatic flush(input int n);
    bit popped;
    bus.state = FLUSHING;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("flush.valid", 32'(bus.out_valid), 0);
      popped = q.size() > 0;
      tick();
      if (popped) void'(q.pop_front());
      ovf_exp = 1'b0;
      chk_status("flush");
      chk("flush.done", 32'(bus.done), 32'(popped && q.size() == 0));
      if (bus.done) done_cnt++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.state     = STANDBY;
    bus.scan_data = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk_reset("rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_reset("stby");
    end

    scan_run(40, 0);
    chk("scan40.prog", 32'(bus.prog), 10);
    chk("scan40.full", 32'(bus.full), 1);
    scan_run(8, 40);
    chk("ovf.set", 32'(bus.overflow), 1);

    done_cnt = 0;
    xfer(10, 1'b1);
    bus.state = IDLE;
    tick();
    chk("xfer1.done_idle", 32'(bus.done), 0);
    chk("xfer1.pulses", done_cnt, 1);

    scan_run(24, 100);
    chk("scan6.prog", 32'(bus.prog), 6);
    done_cnt = 0;
    flush(8);
    chk("flush.pulses", done_cnt, 1);
    chk("flush.ovf", 32'(bus.overflow), 0);

    bus.state = IDLE;
    tick();
    chk_status("idle");
    scan_run(48, 150);
    chk("wrap.ovf", 32'(bus.overflow), 1);
    xfer(5, 1'b0);
    bus.state = STANDBY;
    tick();
    scan_run(12, 200);
    chk("wrap.prog", 32'(bus.prog), 8);
    xfer(8, 1'b1);
    bus.state = IDLE;
    tick();
    scan_run(16, 220);
    xfer(2, 1'b0);

    bus.state     = TRANSFERRING;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    tick();
    q.delete();
    ovf_exp = 1'b0;
    chk_reset("midrst");
    reset = 1'b0;
    tick();
    chk_reset("after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
